// File: rtl/mmio_arb_pkg.sv
// Shared types and helpers for the MMIO bus arbiter.
// Contents: bus width constants, FSM state enum, latched request payload,
// and the round-robin one-hot pick function.
package mmio_arb_pkg;

    localparam int unsigned ADDR_W  = 21;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // One master's transaction as latched at grant time
    typedef struct packed {
        logic              wr;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } mmio_req_t;

    // First set request at or after ptr, wrapping modulo n (n <= MAX_REQ)
    function automatic logic [MAX_REQ-1:0] rr_pick_oh(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int unsigned        idx;
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if ((k < n) && !found && req[idx[2:0]]) begin
                oh[idx[2:0]] = 1'b1;
                found        = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/mmio_bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports: i_req (requests), i_ptr (priority pointer),
//        o_gnt_oh_c (one-hot pick), o_gnt_idx_c (binary index of pick).
module mmio_rr_pick
    import mmio_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]                              i_req,
    input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] i_ptr,
    output logic [N_REQ-1:0]                              o_gnt_oh_c,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_gnt_idx_c
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_oh;

    assign w_req_ext  = MAX_REQ'(i_req);
    assign w_oh       = rr_pick_oh(w_req_ext, 3'(i_ptr), N_REQ);
    assign o_gnt_oh_c = w_oh[N_REQ-1:0];

    // One-hot to binary
    always_comb begin
        o_gnt_idx_c = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (w_oh[i]) o_gnt_idx_c = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter with bounded lock sharing the FPro MMIO bus.
// Each grant: IDLE (latch) -> BUS (one mmio cycle) -> ACK (ack pulse).
// Ports: clk, reset (async active-low); per-master req/req_wr/req_rd/
//        req_lock/req_addr/req_wr_data; gnt/ack per master; rd_data;
//        mmio_* towards the MMIO controller, mmio_rd_data back from it.
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_wr,
    input  logic [N_REQ-1:0]          req_rd,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wr_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      mmio_cs,
    output logic                      mmio_wr,
    output logic                      mmio_rd,
    output logic [ADDR_W-1:0]         mmio_addr,
    output logic [DATA_W-1:0]         mmio_wr_data,
    input  logic [DATA_W-1:0]         mmio_rd_data
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    state_t             r_state,     w_state_nxt;
    logic [IDX_W-1:0]   r_ptr,       w_ptr_nxt;
    logic [IDX_W-1:0]   r_owner,     w_owner_nxt;
    logic [IDX_W-1:0]   r_win,       w_win_nxt;
    logic               r_own_vld,   w_own_vld_nxt;
    logic               r_lock_path, w_lock_path_nxt;
    logic [CNT_W-1:0]   r_lock_cnt,  w_lock_cnt_nxt;
    logic [N_REQ-1:0]   r_gnt,       w_gnt_nxt;
    logic [N_REQ-1:0]   r_ack,       w_ack_nxt;
    logic [DATA_W-1:0]  r_rd_data,   w_rd_data_nxt;
    logic               r_cs,        w_cs_nxt;
    mmio_req_t          r_bus,       w_bus_nxt;

    logic [N_REQ-1:0]   w_rr_oh;
    logic [IDX_W-1:0]   w_rr_idx;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_lock_win;
    logic [CNT_W-1:0]   w_cnt_val;
    mmio_req_t          w_sel;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : IDX_W'(i + IDX_W'(1));
    endfunction

    mmio_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .o_gnt_oh_c  (w_rr_oh),
        .o_gnt_idx_c (w_rr_idx)
    );

    // Lock path wins while the owner still asks and is under its budget
    assign w_lock_win = r_own_vld && req[r_owner] && req_lock[r_owner]
                        && (r_lock_cnt < CNT_W'(MAX_LOCK));
    assign w_win_idx  = w_lock_win ? r_owner : w_rr_idx;

    // Winner's fields; a write takes precedence over a simultaneous read
    always_comb begin
        w_sel.wr      = req_wr[w_win_idx];
        w_sel.rd      = req_rd[w_win_idx] & ~req_wr[w_win_idx];
        w_sel.addr    = req_addr[32'(w_win_idx)*ADDR_W +: ADDR_W];
        w_sel.wr_data = req_wr_data[32'(w_win_idx)*DATA_W +: DATA_W];
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_own_vld_nxt   = r_own_vld;
        w_lock_cnt_nxt  = r_lock_cnt;
        w_win_nxt       = r_win;
        w_lock_path_nxt = r_lock_path;
        w_gnt_nxt       = r_gnt;
        w_rd_data_nxt   = r_rd_data;
        w_ack_nxt       = '0;
        w_cs_nxt        = 1'b0;
        w_bus_nxt       = '0;
        w_cnt_val       = r_lock_path ? CNT_W'(r_lock_cnt + CNT_W'(1)) : CNT_W'(1);

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_win_nxt       = w_win_idx;
                    w_lock_path_nxt = w_lock_win;
                    w_gnt_nxt       = w_lock_win ? (N_REQ'(1) << r_owner) : w_rr_oh;
                    w_cs_nxt        = 1'b1;
                    w_bus_nxt       = w_sel;
                    w_state_nxt     = BUS;
                end
            end
            BUS: begin
                if (r_bus.rd) w_rd_data_nxt = mmio_rd_data;
                w_ack_nxt   = r_gnt;
                w_state_nxt = ACK;
            end
            ACK: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
                if (req_lock[r_win] && (w_cnt_val < CNT_W'(MAX_LOCK))) begin
                    w_owner_nxt    = r_win;
                    w_own_vld_nxt  = 1'b1;
                    w_lock_cnt_nxt = w_cnt_val;
                    if (!r_lock_path) w_ptr_nxt = inc_idx(r_win);
                end else begin
                    // No lock request, or lock budget exhausted: rotate
                    w_own_vld_nxt  = 1'b0;
                    w_lock_cnt_nxt = '0;
                    w_ptr_nxt      = inc_idx(r_win);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_own_vld   <= 1'b0;
            r_lock_cnt  <= '0;
            r_win       <= '0;
            r_lock_path <= 1'b0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rd_data   <= '0;
            r_cs        <= 1'b0;
            r_bus       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_own_vld   <= w_own_vld_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_win       <= w_win_nxt;
            r_lock_path <= w_lock_path_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_cs        <= w_cs_nxt;
            r_bus       <= w_bus_nxt;
        end
    end

    assign gnt          = r_gnt;
    assign ack          = r_ack;
    assign rd_data      = r_rd_data;
    assign mmio_cs      = r_cs;
    assign mmio_wr      = r_bus.wr;
    assign mmio_rd      = r_bus.rd;
    assign mmio_addr    = r_bus.addr;
    assign mmio_wr_data = r_bus.wr_data;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter (N_REQ=2, MAX_LOCK=4).
// Inputs change and outputs are checked on the falling clock edge.
module tb_mmio_bus_arbiter;
    localparam int unsigned N = 2;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req, req_wr, req_rd, req_lock;
    logic [N*21-1:0]  req_addr;
    logic [N*32-1:0]  req_wr_data;
    logic [N-1:0]     gnt, ack;
    logic [31:0]      rd_data, mmio_wr_data, mmio_rd_data, slave_val;
    logic             mmio_cs, mmio_wr, mmio_rd;
    logic [20:0]      mmio_addr;
    int               n_tests, n_fail;

    // Expected grant/ack patterns, one entry per cycle or per transaction
    logic [1:0] fair_gnt [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                  2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [1:0] fair_ack [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                  2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] lock_win [6]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    mmio_bus_arbiter #(.N_REQ(2), .MAX_LOCK(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_wr       (req_wr),
        .req_rd       (req_rd),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .gnt          (gnt),
        .ack          (ack),
        .rd_data      (rd_data),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data)
    );

    assign mmio_rd_data = slave_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_master(input int m, input logic wr, input logic rd, input logic lk,
                              input logic [20:0] addr, input logic [31:0] data);
        req_wr[m]              = wr;
        req_rd[m]              = rd;
        req_lock[m]            = lk;
        req_addr[21*m +: 21]   = addr;
        req_wr_data[32*m +: 32] = data;
    endtask

    task automatic apply_reset();
        req = '0; req_wr = '0; req_rd = '0; req_lock = '0;
        req_addr = '0; req_wr_data = '0; slave_val = '0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // One full transaction for master m; hand-computed expectations passed in
    task automatic run_txn(input string tag, input int m, input logic [1:0] exp_oh,
                           input logic wr, input logic rd, input logic [20:0] addr,
                           input logic [31:0] data, input logic exp_wr, input logic exp_rd,
                           input logic [31:0] exp_rd_data);
        set_master(m, wr, rd, 1'b0, addr, data);
        req[m] = 1'b1;
        tick();
        check_eq({tag, ".bus_cs"},   64'(mmio_cs), 64'(1'b1));
        check_eq({tag, ".bus_wr"},   64'(mmio_wr), 64'(exp_wr));
        check_eq({tag, ".bus_rd"},   64'(mmio_rd), 64'(exp_rd));
        check_eq({tag, ".bus_addr"}, 64'(mmio_addr), 64'(addr));
        check_eq({tag, ".bus_data"}, 64'(mmio_wr_data), 64'(data));
        check_eq({tag, ".bus_gnt"},  64'(gnt), 64'(exp_oh));
        check_eq({tag, ".bus_ack"},  64'(ack), 64'(0));
        tick();
        check_eq({tag, ".ack"},      64'(ack), 64'(exp_oh));
        check_eq({tag, ".ack_gnt"},  64'(gnt), 64'(exp_oh));
        check_eq({tag, ".ack_cs"},   64'(mmio_cs), 64'(1'b0));
        check_eq({tag, ".rd_data"},  64'(rd_data), 64'(exp_rd_data));
        req[m] = 1'b0;
        tick();
        check_eq({tag, ".idle_gnt"}, 64'(gnt), 64'(0));
        check_eq({tag, ".idle_ack"}, 64'(ack), 64'(0));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        #2;
        apply_reset();
        // Outputs while reset is asserted
        reset = 1'b0;
        #1;
        check_eq("rst.gnt",     64'(gnt), 64'(0));
        check_eq("rst.ack",     64'(ack), 64'(0));
        check_eq("rst.rd_data", 64'(rd_data), 64'(0));
        check_eq("rst.mmio",    64'({mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}), 64'(0));
        apply_reset();

        // Single write, then read by master 1, then write by master 0
        run_txn("wr0", 0, 2'b01, 1'b1, 1'b0, 21'h000C0, 32'h000000A5, 1'b1, 1'b0, 32'h0);
        slave_val = 32'h00001234;
        run_txn("rd1", 1, 2'b10, 1'b0, 1'b1, 21'h00100, 32'h0, 1'b0, 1'b1, 32'h00001234);
        slave_val = 32'h00005555;
        run_txn("wr0b", 0, 2'b01, 1'b1, 1'b0, 21'h00004, 32'h00000055, 1'b1, 1'b0, 32'h00001234);
        // Both strobes: write only, read data not captured
        slave_val = 32'hCAFEF00D;
        run_txn("both", 0, 2'b01, 1'b1, 1'b1, 21'h00008, 32'h00000099, 1'b1, 1'b0, 32'h00001234);
        // Neither strobe: chip select only, still acks
        run_txn("none", 1, 2'b10, 1'b0, 1'b0, 21'h00010, 32'h0, 1'b0, 1'b0, 32'h00001234);

        // Fairness with both masters held high
        apply_reset();
        set_master(0, 1'b1, 1'b0, 1'b0, 21'h00001, 32'h11);
        set_master(1, 1'b1, 1'b0, 1'b0, 21'h00002, 32'h22);
        req = 2'b11;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq($sformatf("fair.gnt%0d", i), 64'(gnt), 64'(fair_gnt[i]));
            check_eq($sformatf("fair.ack%0d", i), 64'(ack), 64'(fair_ack[i]));
        end

        // Bounded lock: four master-0 grants, then master 1, then master 0
        apply_reset();
        set_master(0, 1'b1, 1'b0, 1'b1, 21'h00003, 32'h33);
        set_master(1, 1'b1, 1'b0, 1'b0, 21'h00004, 32'h44);
        req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            tick();
            check_eq($sformatf("lock.gnt%0d", t), 64'(gnt), 64'(lock_win[t]));
            tick();
            check_eq($sformatf("lock.ack%0d", t), 64'(ack), 64'(lock_win[t]));
            tick();
            check_eq($sformatf("lock.idle%0d", t), 64'(gnt), 64'(0));
        end

        // Reset during the bus cycle aborts the transaction
        apply_reset();
        set_master(0, 1'b1, 1'b0, 1'b0, 21'h00020, 32'h77);
        req = 2'b01;
        tick();
        check_eq("abort.bus_cs", 64'(mmio_cs), 64'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort.gnt",  64'(gnt), 64'(0));
        check_eq("abort.mmio", 64'({mmio_cs, mmio_wr, mmio_addr, mmio_wr_data}), 64'(0));
        tick();
        check_eq("abort.ack",  64'(ack), 64'(0));
        tick();
        check_eq("abort.ack2", 64'(ack), 64'(0));
        set_master(1, 1'b1, 1'b0, 1'b0, 21'h00030, 32'h88);
        req   = 2'b11;
        reset = 1'b1;
        tick();
        check_eq("abort.regnt",  64'(gnt), 64'(2'b01));
        check_eq("abort.readdr", 64'(mmio_addr), 64'(21'h00020));
        tick();
        check_eq("abort.reack",  64'(ack), 64'(2'b01));
        req = 2'b00;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
